// File: rtl/mem_port_arb_pkg.sv
// mem_port_arbiter shared types: FSM states, grant side,
// starvation counter width and saturating increment.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arbState_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] satInc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arb_fair_ctr.sv
// Saturating count of D grants taken while fetch waits;
// limitHit forces the next grant to the I side.
module mem_port_arb_fair_ctr
  import mem_port_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic             limitHit,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  // clear wins over increment; increment saturates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= satInc(count);
    end
  end

  assign limitHit = (count >= LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// I/D arbiter for one shared variable-latency memory port.
// Optional ack timeout: MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int STARVE_LIMIT  = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0]    i_rdata,
  output logic                     i_ready,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [3:0]               d_be,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  output logic [DATA_WIDTH-1:0]    d_rdata,
  output logic                     d_ready,
  output logic                     stall_f,
  output logic                     stall_m,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [3:0]               mem_be,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     err
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 ||
      TIMEOUT < 1) begin : gBadParam
    $error("mem_port_arbiter: parameter out of range");
  end

  arbState_e state;
  arbState_e stateNext;
  side_e     grantSide;
  side_e     busySide;
  logic      grantVld;
  logic      finish;
  logic      tmoHit;
  logic      limitHit;
  logic      starveInc;
  logic      starveClr;
  logic [CNT_W-1:0] starveCnt;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT);
  logic [TMO_W-1:0] tmoCnt;
`endif

  assign busySide  = (state == BUSY_D) ? SIDE_D : SIDE_I;
  assign starveInc = grantVld && (grantSide == SIDE_D) && i_req;
  assign starveClr = grantVld && !starveInc;

  mem_port_arb_fair_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) uFairCtr (
    .clk     (clk),
    .rst     (rst),
    .inc     (starveInc),
    .clr     (starveClr),
    .limitHit(limitHit),
    .count   (starveCnt)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // D-first arbitration, completion and timeout detect
  always_comb begin
    stateNext = state;
    grantVld  = 1'b0;
    grantSide = SIDE_I;
    finish    = 1'b0;
    tmoHit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && (!i_req || !limitHit)) begin
          grantVld  = 1'b1;
          grantSide = SIDE_D;
          stateNext = BUSY_D;
        end else if (i_req) begin
          grantVld  = 1'b1;
          grantSide = SIDE_I;
          stateNext = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          finish    = 1'b1;
          stateNext = DONE;
        end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        else if (tmoCnt == TMO_LAST) begin
          finish    = 1'b1;
          tmoHit    = 1'b1;
          stateNext = DONE;
        end
`endif
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // latch payload on grant, drop request on completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grantVld) begin
      mem_req <= 1'b1;
      if (grantSide == SIDE_D) begin
        mem_we    <= d_we;
        mem_be    <= d_be;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else begin
        mem_we    <= 1'b0;
        mem_be    <= 4'hF;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
      end
    end else if (finish) begin
      mem_req <= 1'b0;
    end
  end

  // capture read data and pulse the finishing side
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ready <= finish && (busySide == SIDE_I);
      d_ready <= finish && (busySide == SIDE_D);
      if (finish && busySide == SIDE_I) begin
        i_rdata <= tmoHit ? '0 : mem_rdata;
      end
      if (finish && busySide == SIDE_D) begin
        d_rdata <= tmoHit ? '0 : mem_rdata;
      end
    end
  end

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  // cycles spent waiting for ack in BUSY_x
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmoCnt <= '0;
    end else if (grantVld) begin
      tmoCnt <= '0;
    end else if (state == BUSY_I || state == BUSY_D) begin
      tmoCnt <= tmoCnt + 1'b1;
    end
  end

  // one-cycle error pulse alongside the forced ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      err <= tmoHit;
    end
  end
`else
  assign err = 1'b0;
`endif

  assign stall_f = rst & i_req & ~i_ready;
  assign stall_m = rst & d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random bench for mem_port_arbiter with a
// transaction-level memory and arbitration reference.
module tb_mem_port_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int LIM = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [3:0]    d_be = 4'h0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          stall_f;
  logic          stall_m;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .STARVE_LIMIT (LIM),
    .TIMEOUT      (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ready  (i_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .stall_f  (stall_f),
    .stall_m  (stall_m),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .err      (err)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] memArr [256];
  bit   prevReq, riseSeen, expI, expD, iDone, dDone;
  bit   manualMem, curD, curWe;
  int   ackCnt, ackLat, fixedLat, consecD;
  int   dGrants, iGrants;
  logic [31:0] expIData, expDData;

  function automatic logic [7:0] ix(input logic [AW-1:0] a);
    return a[9:2];
  endfunction

  function automatic logic [AW-1:0] rndAddr();
    logic [7:0] w;
    w = 8'($urandom);
    return {6'd0, w, 2'b00};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // one cycle: check outputs at negedge, model grants, respond
  task automatic tick();
    bit rise;
    logic [7:0] k;
    @(negedge clk);
    rise = mem_req && !prevReq;
    riseSeen = rise;
    iDone = i_ready;
    dDone = d_ready;
    chk("stall_f", 32'(stall_f), 32'(rst & i_req & ~i_ready));
    chk("stall_m", 32'(stall_m), 32'(rst & d_req & ~d_ready));
    if (!manualMem) begin
      chk("i_ready", 32'(i_ready), 32'(expI));
      chk("d_ready", 32'(d_ready), 32'(expD));
      chk("err_low", 32'(err), 32'd0);
      if (i_ready) chk("i_rdata", i_rdata, expIData);
      if (d_ready && !curWe) chk("d_rdata", d_rdata, expDData);
    end
    if (rise) begin
      curD = d_req && (!i_req || consecD < LIM);
      chk("grant_any", 32'(i_req | d_req), 32'd1);
      if (curD) begin
        chk("g_d_addr", 32'(mem_addr), 32'(d_addr));
        chk("g_d_we", 32'(mem_we), 32'(d_we));
        chk("g_d_be", 32'(mem_be), 32'(d_be));
        if (d_we) chk("g_d_wdata", mem_wdata, d_wdata);
        curWe = d_we;
        dGrants++;
        consecD = i_req ? ((consecD < 15) ? consecD + 1 : 15) : 0;
      end else begin
        chk("g_i_addr", 32'(mem_addr), 32'(i_addr));
        chk("g_i_we", 32'(mem_we), 32'd0);
        chk("g_i_be", 32'(mem_be), 32'hF);
        curWe = 1'b0;
        iGrants++;
        consecD = 0;
      end
    end
    prevReq = mem_req;
    expI = 1'b0;
    expD = 1'b0;
    if (!manualMem) begin
      if (!mem_req) begin
        mem_ack = 1'b0;
        ackCnt  = 0;
      end else begin
        if (rise)
          ackLat = (fixedLat > 0) ? fixedLat : $urandom_range(1, 4);
        ackCnt++;
        if (ackCnt >= ackLat && !mem_ack) begin
          chk("hold_addr", 32'(mem_addr), 32'(curD ? d_addr : i_addr));
          k = ix(mem_addr);
          if (mem_we)
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) memArr[k][8*b +: 8] = mem_wdata[8*b +: 8];
          mem_ack   = 1'b1;
          mem_rdata = memArr[k];
          if (curD) begin
            expD = 1'b1;
            expDData = memArr[ix(d_addr)];
          end else begin
            expI = 1'b1;
            expIData = memArr[ix(i_addr)];
          end
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
      end
    end
  endtask

  task automatic waitReady(input bit sideD, input int maxc,
                           output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(sideD ? dDone : iDone) && n < maxc);
    chk(sideD ? "wait_d_ready" : "wait_i_ready",
        32'(sideD ? dDone : iDone), 32'd1);
  endtask

  task automatic waitRise(input int maxc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!riseSeen && n < maxc);
    chk("wait_mem_req", 32'(riseSeen), 32'd1);
  endtask

  initial begin
    int n;
    int iG0;
    logic [31:0] old;
    for (int a = 0; a < 256; a++) memArr[a] = $urandom;
    memArr[ix(16'h0040)] = 32'hDEADBEEF;
    fixedLat = 1;

    // reset: outputs quiet even with a request present
    repeat (2) tick();
    i_req  = 1'b1;
    i_addr = 16'h0040;
    tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_cnt", 32'(dut.uFairCtr.count), 32'd0);
    rst = 1'b1;

    // 1: simple fetch
    fixedLat = 2;
    waitRise(10);
    chk("t1_stall_f", 32'(stall_f), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h0040);
    waitReady(1'b0, 20, n);
    chk("t1_lat", n, 2);
    chk("t1_rdata", i_rdata, 32'hDEADBEEF);
    i_req = 1'b0;
    tick();
    chk("t1_one_pulse", 32'(i_ready), 32'd0);

    // 2: simultaneous requests, D first
    fixedLat = 1;
    iG0 = iGrants;
    i_req = 1'b1; i_addr = 16'h0080;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 16'h1000;
    waitReady(1'b1, 20, n);
    chk("t2_d_first", iGrants, iG0);
    d_req = 1'b0;
    waitReady(1'b0, 20, n);
    chk("t2_gap", n, 3);
    i_req = 1'b0;
    tick();

    // 3: starvation limit
    dGrants = 0; iGrants = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = rndAddr();
    i_req = 1'b1; i_addr = rndAddr();
    n = 0;
    do begin
      tick();
      n++;
      if (dDone) d_addr = rndAddr();
    end while (!iDone && n < 80);
    chk("t3_i_done", 32'(iDone), 32'd1);
    chk("t3_d_grants", dGrants, LIM);
    chk("t3_i_grants", iGrants, 1);
    chk("t3_cnt_clr", 32'(dut.uFairCtr.count), 32'd0);
    i_req = 1'b0;
    waitReady(1'b1, 20, n);
    d_req = 1'b0;
    tick();

    // 4: partial store then readback
    old = memArr[ix(16'h2004)];
    fixedLat = 2;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011;
    d_addr = 16'h2004; d_wdata = 32'h12345678;
    waitRise(10);
    chk("t4_we", 32'(mem_we), 32'd1);
    chk("t4_be", 32'(mem_be), 32'h3);
    chk("t4_addr", 32'(mem_addr), 32'h2004);
    chk("t4_wdata", mem_wdata, 32'h12345678);
    waitReady(1'b1, 20, n);
    d_req = 1'b0;
    tick();
    chk("t4_one_pulse", 32'(d_ready), 32'd0);
    d_req = 1'b1; d_we = 1'b0;
    waitReady(1'b1, 20, n);
    chk("t4_readback", d_rdata, {old[31:16], 16'h5678});
    d_req = 1'b0;
    tick();

    // 5: reset in BUSY_D drops mem_req at once
    fixedLat = 100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h1000;
    waitRise(10);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("t5_mem_req", 32'(mem_req), 32'd0);
    chk("t5_d_ready", 32'(d_ready), 32'd0);
    chk("t5_stall_m", 32'(stall_m), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    consecD = 0;
    fixedLat = 2;
    waitReady(1'b1, 20, n);
    chk("t5_rdata", d_rdata, memArr[ix(16'h1000)]);
    d_req = 1'b0;
    tick();

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    // 6: ack timeout
    manualMem = 1'b1;
    mem_ack = 1'b0;
    i_req = 1'b1; i_addr = 16'h0100;
    waitRise(10);
    n = 0;
    do begin
      tick();
      n++;
    end while (!iDone && n < 30);
    chk("t6_tmo_lat", n, TMO + 1);
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_rdata", i_rdata, 32'd0);
    i_req = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    repeat (3) begin
      tick();
      chk("t6_late_req", 32'(mem_req), 32'd0);
      chk("t6_late_rdy", 32'(i_ready), 32'd0);
      chk("t6_late_err", 32'(err), 32'd0);
    end
    mem_ack = 1'b0;
    manualMem = 1'b0;
    tick();
`endif

    // random traffic against the reference
    fixedLat = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (iDone) i_req = 1'b0;
      if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req = 1'b1;
        i_addr = rndAddr();
      end
      if (dDone) d_req = 1'b0;
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom);
        d_be = 4'($urandom);
        d_addr = rndAddr();
        d_wdata = $urandom;
      end
    end
    n = 0;
    while ((i_req || d_req) && n < 200) begin
      tick();
      n++;
      if (iDone) i_req = 1'b0;
      if (dDone) d_req = 1'b0;
    end
    chk("drain", 32'(i_req | d_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
